// File: rtl/button_sync_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, debounce filter and press/held FSM per channel.
// Optional auto-repeat of Press while a button is held: define BUTTON_AUTO_REPEAT_EN.
module button_sync_debounce_multi #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] Bi,
  output logic [NUM_BTN-1:0] Level,
  output logic [NUM_BTN-1:0] Press,
  output logic [NUM_BTN-1:0] Release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no effect in this build; the empty block only marks an illegal setting.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_param
  end
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_bit;
    logic [CNT_W-1:0]       deb_cnt_p1;
    logic                   level_p1;
    state_t                 state_p2;
    logic                   press_p2;
    logic                   rel_p2;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic [RPT_W-1:0]       rpt_cnt_p2;
    logic                   rpt_armed_p2;
`endif

    assign sync_bit = sync_p0[SYNC_STAGES-1];

    // Stage 0/1: synchroniser chain and consecutive-sample debounce
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        sync_p0    <= '0;
        deb_cnt_p1 <= '0;
        level_p1   <= 1'b0;
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], Bi[i]};
        if (sync_bit == level_p1) begin
          deb_cnt_p1 <= '0;
        end else if (deb_cnt_p1 == CNT_LAST) begin
          level_p1   <= sync_bit;
          deb_cnt_p1 <= '0;
        end else begin
          deb_cnt_p1 <= deb_cnt_p1 + 1'b1;
        end
      end
    end

    // Stage 2: press/held FSM; pulses are registered with the state they belong to
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state_p2     <= S_IDLE;
        press_p2     <= 1'b0;
        rel_p2       <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt_cnt_p2   <= '0;
        rpt_armed_p2 <= 1'b0;
`endif
      end else begin
        press_p2 <= 1'b0;
        rel_p2   <= 1'b0;
        case (state_p2)
          S_IDLE: begin
            if (level_p1) begin
              state_p2 <= S_PRESS;
              press_p2 <= 1'b1;
            end
          end
          S_PRESS: begin
`ifdef BUTTON_AUTO_REPEAT_EN
            rpt_cnt_p2   <= '0;
            rpt_armed_p2 <= 1'b0;
`endif
            if (level_p1) begin
              state_p2 <= S_HELD;
            end else begin
              state_p2 <= S_RELEASE;
              rel_p2   <= 1'b1;
            end
          end
          S_HELD: begin
            if (!level_p1) begin
              state_p2 <= S_RELEASE;
              rel_p2   <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
              rpt_cnt_p2   <= '0;
              rpt_armed_p2 <= 1'b0;
            end else if (rpt_cnt_p2 == (rpt_armed_p2 ? RPT_PER_LAST : RPT_DLY_LAST)) begin
              // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD
              press_p2     <= 1'b1;
              rpt_cnt_p2   <= '0;
              rpt_armed_p2 <= 1'b1;
            end else begin
              rpt_cnt_p2 <= rpt_cnt_p2 + 1'b1;
`endif
            end
          end
          S_RELEASE: begin
            if (level_p1) begin
              state_p2 <= S_PRESS;
              press_p2 <= 1'b1;
            end else begin
              state_p2 <= S_IDLE;
            end
          end
          default: state_p2 <= S_IDLE;
        endcase
      end
    end

    assign Level[i]   = level_p1;
    assign Press[i]   = press_p2;
    assign Release[i] = rel_p2;
  end

endmodule

// File: tb/tb_button_sync_debounce_multi.sv
// Bench for button_sync_debounce_multi: directed scenarios plus random toggling,
// compared each cycle against a sample-history reference model.
module tb_button_sync_debounce_multi;

  localparam int NB = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic          Clk;
  logic          Reset;
  logic [NB-1:0] Bi;
  logic [NB-1:0] Level;
  logic [NB-1:0] Press;
  logic [NB-1:0] Release;

  button_sync_debounce_multi #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Bi(Bi),
    .Level(Level), .Press(Press), .Release(Release)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: raw samples since reset, level flips when the last DC synced samples all disagree
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_lvl, m_lvl_d, m_press, m_rel;
  int            m_e;
  int            m_pe[NB];

  int pcnt[NB], rcnt[NB], pfirst[NB], rfirst[NB];

  function automatic logic [NB-1:0] bi_at(input int idx);
    return (idx < 0) ? '0 : hist[idx];
  endfunction

  task automatic model_clear();
    hist.delete();
    m_lvl = '0; m_lvl_d = '0; m_press = '0; m_rel = '0;
    m_e = -1;
    for (int c = 0; c < NB; c++) m_pe[c] = -1;
  endtask

  task automatic model_edge(input logic [NB-1:0] b);
    logic [NB-1:0] nl, s;
    logic          all_mis;
    hist.push_back(b);
    m_e = hist.size() - 1;
    m_press = m_lvl & ~m_lvl_d;
    m_rel   = ~m_lvl & m_lvl_d;
    for (int c = 0; c < NB; c++) begin
      if (m_press[c]) m_pe[c] = m_e;
`ifdef BUTTON_AUTO_REPEAT_EN
      else if (m_lvl[c] && m_lvl_d[c] && m_pe[c] >= 0) begin
        int k;
        k = m_e - m_pe[c];
        if (k >= 1 + RD && ((k - 1 - RD) % RP) == 0) m_press[c] = 1'b1;
      end
`endif
    end
    for (int c = 0; c < NB; c++) begin
      all_mis = 1'b1;
      for (int j = 0; j < DC; j++) begin
        s = bi_at(m_e - SS - j);
        if (s[c] == m_lvl[c]) all_mis = 1'b0;
      end
      nl[c] = all_mis ? ~m_lvl[c] : m_lvl[c];
    end
    m_lvl_d = m_lvl;
    m_lvl   = nl;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      pcnt[c] = 0; rcnt[c] = 0; pfirst[c] = -1; rfirst[c] = -1;
    end
  endtask

  task automatic tick(input logic [NB-1:0] b);
    Bi = b;
    @(posedge Clk);
    if (Reset) model_clear();
    else model_edge(b);
    #1;
    check_val("level", Level, m_lvl);
    check_val("press", Press, m_press);
    check_val("release", Release, m_rel);
    check_val("press_and_release", Press & Release, '0);
    for (int c = 0; c < NB; c++) begin
      if (Press[c]) begin
        pcnt[c]++;
        if (pfirst[c] < 0) pfirst[c] = m_e;
      end
      if (Release[c]) begin
        rcnt[c]++;
        if (rfirst[c] < 0) rfirst[c] = m_e;
      end
    end
  endtask

  task automatic async_reset_pulse();
    #2 Reset = 1'b1;
    #1;
    model_clear();
    check_val("async_rst_level", Level, '0);
    check_val("async_rst_press", Press, '0);
    check_val("async_rst_release", Release, '0);
  endtask

  int base;
  logic [NB-1:0] cur;

  initial begin
    model_clear();
    clear_counts();
    Reset = 1'b1;
    Bi    = '0;

    // Held buttons during reset: silent, then one Press per channel together
    for (int k = 0; k < 4; k++) tick(4'hF);
    Reset = 1'b0;
    clear_counts();
    for (int k = 0; k < 12; k++) tick(4'hF);
    for (int c = 0; c < NB; c++) begin
      check_val("rst_hold_pcnt", pcnt[c], 1);
      check_val("rst_hold_pfirst", pfirst[c], SS + DC);
    end
    for (int k = 0; k < 12; k++) tick(4'h0);
    check_val("rst_hold_rfirst", rfirst[0], 12 + SS + DC);

    // Single long press on channel 0
    clear_counts();
    base = m_e + 1;
    for (int k = 0; k < 20; k++) tick(4'h1);
    for (int k = 0; k < 12; k++) tick(4'h0);
    check_val("ch0_pfirst", pfirst[0], base + SS + DC);
`ifdef BUTTON_AUTO_REPEAT_EN
    check_val("ch0_pcnt", pcnt[0], 4);
`else
    check_val("ch0_pcnt", pcnt[0], 1);
`endif
    check_val("ch0_rfirst", rfirst[0], base + 20 + SS + DC);
    check_val("ch0_rcnt", rcnt[0], 1);

    // Short glitch on channel 1 never reaches the outputs
    clear_counts();
    for (int k = 0; k < 3; k++) tick(4'h2);
    for (int k = 0; k < 10; k++) tick(4'h0);
    check_val("glitch_pcnt", pcnt[1], 0);
    check_val("glitch_rcnt", rcnt[1], 0);

    // Staggered presses on channels 2 and 3
    clear_counts();
    for (int k = 0; k < 2; k++) tick(4'h4);
    for (int k = 0; k < 15; k++) tick(4'hC);
    check_val("stagger_gap", pfirst[3] - pfirst[2], 2);
    check_val("stagger_ch01", pcnt[0] + pcnt[1], 0);
    for (int k = 0; k < 12; k++) tick(4'h0);

    // Asynchronous reset while channel 0 is down: no Release, re-press afterwards
    clear_counts();
    for (int k = 0; k < 10; k++) tick(4'h1);
    check_val("pre_rst_level", Level[0], 1'b1);
    async_reset_pulse();
    for (int k = 0; k < 3; k++) tick(4'h1);
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) tick(4'h1);
    check_val("rst_mid_rcnt", rcnt[0], 0);
    check_val("rst_mid_pcnt", pcnt[0], 2);
    for (int k = 0; k < 12; k++) tick(4'h0);

    // Random per-channel toggling with occasional asynchronous resets
    cur = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse();
        tick(cur);
        Reset = 1'b0;
      end
      tick(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
